// File: rtl/alu_cmd_driver.sv
// Command front-end for a combinational 4-bit ALU: registers one command at a time,
// captures the ALU result with an error flag, and queues it in a show-ahead response FIFO.
module alu_cmd_driver #(
    parameter int DATA_W     = 4,
    parameter int OP_W       = 8,
    parameter int RES_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [OP_W-1:0]                 cmd_opcode,
    input  logic [DATA_W-1:0]               cmd_a,
    input  logic [DATA_W-1:0]               cmd_b,
    output logic [DATA_W-1:0]               alu_a,
    output logic [DATA_W-1:0]               alu_b,
    output logic [OP_W-1:0]                 alu_opcode,
    input  logic [RES_W-1:0]                alu_result,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [RES_W-1:0]                rsp_data,
    output logic                            rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]     rsp_count,
    output logic                            busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
    logic                busy_q, busy_d;

    logic [RES_W-1:0]    mem_data_q [FIFO_DEPTH];
    logic                mem_err_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic                accept, push, pop, head_from_push;
    logic                push_err;
    logic [RES_W-1:0]    push_data;

    always_comb begin
        cmd_ready = (state_q == IDLE) && (count_q < CNT_W'(FIFO_DEPTH));
        accept    = cmd_valid && cmd_ready;
        push      = (state_q == EXEC);
        pop       = (count_q != '0) && rsp_ready;

        // Undefined opcodes and divide/modulo by zero report an error with zero data.
        push_err  = (alu_opcode_q > OP_W'(8'h0F)) ||
                    (((alu_opcode_q == OP_W'(8'h03)) || (alu_opcode_q == OP_W'(8'h04))) &&
                     (alu_b_q == '0));
        push_data = push_err ? '0 : alu_result;

        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        if (state_q == IDLE) begin
            if (accept) begin
                alu_a_d      = cmd_a;
                alu_b_d      = cmd_b;
                alu_opcode_d = cmd_opcode;
                state_d      = EXEC;
            end
        end else begin
            state_d = IDLE;
        end
        busy_d = (state_d == EXEC);

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The new entry becomes head only when nothing older remains after this cycle's pop.
        head_from_push = (count_q == '0) || ((count_q == CNT_W'(1)) && pop);
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (count_d != '0) begin
            if (head_from_push) begin
                rsp_data_d = push_data;
                rsp_err_d  = push_err;
            end else begin
                rsp_data_d = mem_data_q[rd_ptr_d];
                rsp_err_d  = mem_err_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            busy_q       <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_err_q[i]  <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            busy_q       <= busy_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            if (push) begin
                mem_data_q[wr_ptr_q] <= push_data;
                mem_err_q[wr_ptr_q]  <= push_err;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign busy       = busy_q;
    assign rsp_valid  = (count_q != '0);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_count  = count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a small behavioural ALU attached to the alu_* port.
module tb_alu_cmd_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [2:0] rsp_count;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    alu_cmd_driver #(
        .DATA_W(4), .OP_W(8), .RES_W(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_count(rsp_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in: nonzero garbage on undefined opcodes / zero divisors so error zeroing is visible.
    always_comb begin
        logic [7:0] a8, b8;
        a8 = {4'b0, alu_a};
        b8 = {4'b0, alu_b};
        case (alu_opcode)
            8'h00:   alu_result = a8 + b8;
            8'h01:   alu_result = a8 - b8;
            8'h02:   alu_result = a8 * b8;
            8'h03:   alu_result = (b8 == 0) ? 8'hEE : a8 / b8;
            8'h04:   alu_result = (b8 == 0) ? 8'hEE : a8 % b8;
            8'h05:   alu_result = (alu_b == 4'd2) ? a8 * a8 : 8'hCC;
            8'h09:   alu_result = {alu_a, alu_b};
            default: alu_result = 8'hFF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers a command from a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b);
        int i;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        i = 0;
        while (!cmd_ready && i < 64) begin
            @(negedge clk);
            i++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_opcode = 8'h5A;
        cmd_a      = 4'hF;
        cmd_b      = 4'hF;
        $display("cmd op=%02h a=%0h b=%0h accepted at %0t", op, a, b, $time);
    endtask

    // Full round trip with rsp_ready high: checks the registered ALU drive, then the response.
    task automatic run_cmd(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_data, input logic exp_err);
        send_cmd(op, a, b);
        check("exec_busy", busy, 1'b1);
        check("exec_cmd_ready", cmd_ready, 1'b0);
        check("alu_opcode", alu_opcode, op);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        check("busy_after", busy, 1'b0);
        $display("rsp op=%02h data=%02h err=%0b", op, rsp_data, rsp_err);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 8'h00;
        cmd_a      = 4'h0;
        cmd_b      = 4'h0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_count", rsp_count, 3'd0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alu", {alu_opcode, alu_a, alu_b}, 16'h0000);

        // Basic operations and error rules
        rsp_ready = 1'b1;
        run_cmd(8'h00, 4'd7, 4'd9, 8'h10, 1'b0);
        run_cmd(8'h09, 4'hA, 4'h5, 8'hA5, 1'b0);
        run_cmd(8'h05, 4'd3, 4'd2, 8'h09, 1'b0);
        run_cmd(8'h03, 4'd6, 4'd0, 8'h00, 1'b1);
        run_cmd(8'h20, 4'd1, 4'd1, 8'h00, 1'b1);
        run_cmd(8'h03, 4'd9, 4'd2, 8'h04, 1'b0);
        run_cmd(8'h04, 4'd7, 4'd0, 8'h00, 1'b1);
        run_cmd(8'h04, 4'd7, 4'd3, 8'h01, 1'b0);
        @(negedge clk);
        check("drain_count", rsp_count, 3'd0);
        check("hold_last_data", rsp_data, 8'h01);

        // Fill the FIFO with rsp_ready low
        rsp_ready = 1'b0;
        send_cmd(8'h00, 4'd1, 4'd1);
        send_cmd(8'h00, 4'd2, 4'd2);
        send_cmd(8'h00, 4'd3, 4'd3);
        send_cmd(8'h00, 4'd4, 4'd4);
        check("fill_count3", rsp_count, 3'd3);
        @(negedge clk);
        check("full_count", rsp_count, 3'd4);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_head", rsp_data, 8'h02);
        cmd_opcode = 8'h00;
        cmd_a      = 4'd5;
        cmd_b      = 4'd5;
        cmd_valid  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_cmd_ready", cmd_ready, 1'b0);
            check("stall_busy", busy, 1'b0);
            check("stall_head", rsp_data, 8'h02);
            check("stall_count", rsp_count, 3'd4);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pop1_head", rsp_data, 8'h04);
        check("pop1_count", rsp_count, 3'd3);
        check("pop1_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pop2_head", rsp_data, 8'h06);
        check("pop2_count", rsp_count, 3'd2);
        check("pop2_busy", busy, 1'b1);
        check("pop2_alu_a", alu_a, 4'd5);
        @(negedge clk);
        check("pop3_head", rsp_data, 8'h08);
        check("pop3_count", rsp_count, 3'd2);
        @(negedge clk);
        check("pop4_head", rsp_data, 8'h0A);
        check("pop4_count", rsp_count, 3'd1);
        @(negedge clk);
        check("empty_count", rsp_count, 3'd0);
        check("empty_valid", rsp_valid, 1'b0);
        check("empty_hold", rsp_data, 8'h0A);
        $display("fifo fill/drain sequence done at %0t", $time);

        // Simultaneous push and pop with one entry queued
        rsp_ready = 1'b0;
        send_cmd(8'h00, 4'd1, 4'd2);
        @(negedge clk);
        check("sim_pre_count", rsp_count, 3'd1);
        check("sim_pre_head", rsp_data, 8'h03);
        send_cmd(8'h02, 4'd3, 4'd3);
        check("sim_exec_count", rsp_count, 3'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("sim_count", rsp_count, 3'd1);
        check("sim_valid", rsp_valid, 1'b1);
        check("sim_head", rsp_data, 8'h09);
        check("sim_err", rsp_err, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("sim_drain", rsp_count, 3'd0);
        $display("simultaneous push/pop done at %0t", $time);

        // Reset while in EXEC with two entries queued
        rsp_ready = 1'b0;
        send_cmd(8'h00, 4'd1, 4'd1);
        send_cmd(8'h00, 4'd2, 4'd2);
        send_cmd(8'h00, 4'd3, 4'd3);
        check("prerst_count", rsp_count, 3'd2);
        check("prerst_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", rsp_valid, 1'b0);
        check("arst_count", rsp_count, 3'd0);
        check("arst_alu", {alu_opcode, alu_a, alu_b}, 16'h0000);
        check("arst_busy", busy, 1'b0);
        check("arst_data", rsp_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_valid", rsp_valid, 1'b0);
        check("postrst_count", rsp_count, 3'd0);
        rsp_ready = 1'b1;
        run_cmd(8'h00, 4'd2, 4'd3, 8'h05, 1'b0);
        @(negedge clk);
        check("final_count", rsp_count, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential front-end that accepts ALU commands (opcode, a, b) over a valid/ready handshake.
- Drives registered operands and opcode into the combinational 4-bit ALU and captures its 8-bit result.
- Queues each result with an error flag in a small show-ahead FIFO, presented on a valid/ready response port.
- Sits between the instruction source/testbench sequencer and the ALU; it is the initiator for the ALU interface.

Parameters:
- DATA_W, 4, operand width (matches ALU a/b)
- OP_W, 8, opcode width
- RES_W, 8, result width
- FIFO_DEPTH, 4, response FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk rise
- cmd_opcode  in  OP_W  command opcode
- cmd_a  in  DATA_W  operand a
- cmd_b  in  DATA_W  operand b
- alu_a  out  DATA_W  registered operand a to ALU
- alu_b  out  DATA_W  registered operand b to ALU
- alu_opcode  out  OP_W  registered opcode to ALU
- alu_result  in  RES_W  combinational ALU output
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  head consumed when rsp_valid & rsp_ready at clk rise
- rsp_data  out  RES_W  head result
- rsp_err  out  1  head error flag
- rsp_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  high in EXEC state

Behaviour:
- Reset (rst_n low, async, any state):
  - state=IDLE; alu_a/alu_b/alu_opcode=0; FIFO empty; rsp_count=0; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0.
  - Any in-flight command is discarded.
- FSM states:
  - IDLE: cmd_ready = (rsp_count < FIFO_DEPTH), combinational. On accept, register cmd_a/cmd_b/cmd_opcode onto alu_* and go to EXEC. With no accept, stay in IDLE with alu_* held.
  - EXEC: cmd_ready=0; busy=1. At end of cycle, push {err, data} into the FIFO and return to IDLE.
- Timing:
  - Throughput: one command per 2 cycles.
  - Latency: command accepted at edge N -> alu_* valid after N -> result pushed at edge N+1 -> rsp_valid high after N+1 if FIFO was empty.
- Error and data rules, evaluated on the registered alu_opcode/alu_b:
  - alu_opcode > 8'h0F: err=1, data=8'h00.
  - alu_opcode is 8'h03 or 8'h04 and alu_b==0 (divide/modulo by zero): err=1, data=8'h00.
  - Otherwise: err=0, data=alu_result; all 8 bits are stored unmodified.
- FIFO:
  - Show-ahead: rsp_data/rsp_err reflect the head whenever rsp_valid=1, and are held at the last popped value when empty.
  - Strict in-order delivery.
  - Wrap-around of read/write pointers modulo FIFO_DEPTH.
- Full-FIFO rule: admission in IDLE reserves the slot. In EXEC only pops can occur before the push, so overflow is impossible and there is no overflow logic.
- Simultaneous push (EXEC end) and pop: rsp_count unchanged; the new entry is appended behind the remaining entries. If the FIFO held exactly 1 entry, the new entry becomes head next cycle and rsp_valid stays high.
- rsp_ready while empty: no effect.
- Handshake holding:
  - cmd_* are sampled only on accept; changes while cmd_ready=0 are ignored.
  - rsp_data/rsp_err must not change while rsp_valid=1 and rsp_ready=0.

Test Plan:
- Release rst_n, idle 3 cycles -> all outputs 0 except cmd_ready=1; rsp_count=0.
- Send op 8'h00 a=7 b=9, rsp_ready=1 -> alu_opcode=00 one cycle after accept; rsp_valid two cycles after accept with rsp_data=8'h10, rsp_err=0. Then op 8'h09 a=4'hA b=4'h5 -> 8'hA5. Then op 8'h05 a=3 b=2 -> 8'h09.
- Send op 8'h03 a=6 b=0 -> rsp_data=8'h00, rsp_err=1. Send op 8'h20 a=1 b=1 -> rsp_data=8'h00, rsp_err=1. Send op 8'h03 a=9 b=2 -> 8'h04, rsp_err=0.
- Hold rsp_ready=0 and stream 5 adds (1+1 ... 5+5) with FIFO_DEPTH=4:
  - Fourth result pushed -> rsp_count=4, cmd_ready=0, fifth command stalls with head stable at 8'h02.
  - Then rsp_ready=1 -> outputs 02,04,06,08 in order, fifth command accepted, output 0A.
  - rsp_count returns to 0.
- Leave rsp_ready=1 with one entry queued while a command is in EXEC -> simultaneous push/pop, rsp_count unchanged, rsp_valid stays high, next head equals new result.
- Assert rst_n low during EXEC with 2 entries queued -> immediately rsp_valid=0, rsp_count=0, alu_*=0, busy=0. After release, no stale result appears and the next command 2+3 returns 8'h05.
